// File: rtl/pkfb_packetizer.sv
// pkfb_packetizer
// Fabric-side producer for the hard-block packet FIFO interface. Sensor words
// arrive on a valid/ready stream, are buffered in a small local FIFO and are
// emitted as fixed-length packets: SOF marks the first word, EOF the last.
// The hard-block overflow indication is tracked as a sticky flag plus a
// saturating cycle count, and completed packets are counted for firmware.
//
// Ports
//   Sys_PKfb_Clk     sole clock
//   Sys_PKfb_Rst     synchronous active-high reset
//   en               allows a new packet to start (sampled in IDLE only)
//   fifo_sel         destination FIFO index, latched at packet start
//   src_data/valid   input word stream; src_ready = local FIFO not full
//   FB_PKfbData      registered output word (holds when no push)
//   FB_PKfbPush      registered one-hot push strobe, one cycle per word
//   FB_PKfbSOF/EOF   registered first/last word markers
//   FB_PKfbOverflow  overflow indication from the hard block
//   ovf_clr          clears ovf_sticky and ovf_cnt (overflow wins if both)
//   ovf_sticky       sticky overflow flag
//   ovf_cnt          saturating count of overflow cycles
//   pkt_cnt          completed packets, wraps
//   busy             a packet is in progress (state SEND)
module pkfb_packetizer #(
   parameter int DEPTH     = 8,
   parameter int PKT_WORDS = 16
) (
   input  logic        Sys_PKfb_Clk,
   input  logic        Sys_PKfb_Rst,
   input  logic        en,
   input  logic [1:0]  fifo_sel,
   input  logic [31:0] src_data,
   input  logic        src_valid,
   output logic        src_ready,
   output logic [31:0] FB_PKfbData,
   output logic [3:0]  FB_PKfbPush,
   output logic        FB_PKfbSOF,
   output logic        FB_PKfbEOF,
   input  logic        FB_PKfbOverflow,
   input  logic        ovf_clr,
   output logic        ovf_sticky,
   output logic [7:0]  ovf_cnt,
   output logic [15:0] pkt_cnt,
   output logic        busy
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
   localparam logic [16:0]   PKT_LAST = 17'(PKT_WORDS);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_t;

   logic [31:0]   mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q;
   logic [PW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   state_t        state_q;
   logic [1:0]    sel_q;
   logic [1:0]    sel_d;
   logic [15:0]   word_cnt_q;
   logic [31:0]   data_q;
   logic [3:0]    push_q;
   logic          sof_q;
   logic          eof_q;
   logic          ovf_sticky_q;
   logic [7:0]    ovf_cnt_q;
   logic [15:0]   pkt_cnt_q;

   logic empty_s;
   logic full_s;
   logic wr_s;
   logic pop_s;
   logic last_s;

   // FIFO status, pop decision and next occupancy
   always_comb begin
      empty_s = (count_q == '0);
      full_s  = (count_q == FULL_CNT);
      // A write needs a free slot at the start of the cycle; a same-cycle
      // pop does not make room for it.
      wr_s    = src_valid & ~full_s;
      // IDLE needs en to open a packet; SEND drains whenever data exists.
      if (state_q == S_SEND) begin
         pop_s = ~empty_s;
         sel_d = sel_q;
      end else begin
         pop_s = ~empty_s & en;
         sel_d = fifo_sel;
      end
      // word_cnt_q counts words already emitted in this packet, so the word
      // being popped now is number word_cnt_q+1.
      last_s  = (({1'b0, word_cnt_q} + 17'd1) == PKT_LAST);
      count_d = count_q + CW'(wr_s) - CW'(pop_s);
   end

   // FIFO storage; contents need no reset because occupancy gates reads
   always_ff @(posedge Sys_PKfb_Clk) begin
      if (wr_s) begin
         mem_q[wr_ptr_q] <= src_data;
      end
   end

   // Packet FSM, FIFO pointers, registered outputs and status counters
   always_ff @(posedge Sys_PKfb_Clk) begin
      if (Sys_PKfb_Rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         state_q      <= S_IDLE;
         sel_q        <= 2'd0;
         word_cnt_q   <= 16'd0;
         data_q       <= 32'd0;
         push_q       <= 4'd0;
         sof_q        <= 1'b0;
         eof_q        <= 1'b0;
         ovf_sticky_q <= 1'b0;
         ovf_cnt_q    <= 8'd0;
         pkt_cnt_q    <= 16'd0;
      end else begin
         count_q <= count_d;
         if (wr_s) begin
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         push_q <= 4'd0;
         sof_q  <= 1'b0;
         eof_q  <= 1'b0;
         if (pop_s) begin
            rd_ptr_q <= rd_ptr_q + PW'(1);
            data_q   <= mem_q[rd_ptr_q];
            push_q   <= 4'b0001 << sel_d;
            sel_q    <= sel_d;
            sof_q    <= (state_q == S_IDLE);
            eof_q    <= last_s;
            if (last_s) begin
               pkt_cnt_q  <= pkt_cnt_q + 16'd1;
               word_cnt_q <= 16'd0;
               state_q    <= S_IDLE;
            end else begin
               word_cnt_q <= word_cnt_q + 16'd1;
               state_q    <= S_SEND;
            end
         end
         // Overflow beats clear: a clear in an overflow cycle restarts at 1.
         if (FB_PKfbOverflow) begin
            ovf_sticky_q <= 1'b1;
            if (ovf_clr) begin
               ovf_cnt_q <= 8'd1;
            end else if (ovf_cnt_q != 8'hFF) begin
               ovf_cnt_q <= ovf_cnt_q + 8'd1;
            end
         end else if (ovf_clr) begin
            ovf_sticky_q <= 1'b0;
            ovf_cnt_q    <= 8'd0;
         end
      end
   end

   assign src_ready   = ~full_s;
   assign FB_PKfbData = data_q;
   assign FB_PKfbPush = push_q;
   assign FB_PKfbSOF  = sof_q;
   assign FB_PKfbEOF  = eof_q;
   assign ovf_sticky  = ovf_sticky_q;
   assign ovf_cnt     = ovf_cnt_q;
   assign pkt_cnt     = pkt_cnt_q;
   assign busy        = (state_q == S_SEND);

endmodule

// File: tb/tb_pkfb_packetizer.sv
module tb_pkfb_packetizer;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  p;
      logic        sof;
      logic        eof;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // instance A: PKT_WORDS=4
   logic        en_a = 1'b0;
   logic [1:0]  sel_a = 2'd0;
   logic [31:0] din_a = 32'd0;
   logic        vld_a = 1'b0;
   logic        rdy_a;
   logic [31:0] dat_a;
   logic [3:0]  push_a;
   logic        sof_a, eof_a;
   logic        ovf_a = 1'b0;
   logic        clr_a = 1'b0;
   logic        stk_a;
   logic [7:0]  ocnt_a;
   logic [15:0] pcnt_a;
   logic        busy_a;

   // instance B: PKT_WORDS=1
   logic        en_b = 1'b0;
   logic [1:0]  sel_b = 2'd0;
   logic [31:0] din_b = 32'd0;
   logic        vld_b = 1'b0;
   logic        rdy_b;
   logic [31:0] dat_b;
   logic [3:0]  push_b;
   logic        sof_b, eof_b;
   logic        ovf_b = 1'b0;
   logic        clr_b = 1'b0;
   logic        stk_b;
   logic [7:0]  ocnt_b;
   logic [15:0] pcnt_b;
   logic        busy_b;

   pkfb_packetizer #(.DEPTH(8), .PKT_WORDS(4)) dut_a (
      .Sys_PKfb_Clk(clk), .Sys_PKfb_Rst(rst), .en(en_a), .fifo_sel(sel_a),
      .src_data(din_a), .src_valid(vld_a), .src_ready(rdy_a),
      .FB_PKfbData(dat_a), .FB_PKfbPush(push_a), .FB_PKfbSOF(sof_a),
      .FB_PKfbEOF(eof_a), .FB_PKfbOverflow(ovf_a), .ovf_clr(clr_a),
      .ovf_sticky(stk_a), .ovf_cnt(ocnt_a), .pkt_cnt(pcnt_a), .busy(busy_a));

   pkfb_packetizer #(.DEPTH(8), .PKT_WORDS(1)) dut_b (
      .Sys_PKfb_Clk(clk), .Sys_PKfb_Rst(rst), .en(en_b), .fifo_sel(sel_b),
      .src_data(din_b), .src_valid(vld_b), .src_ready(rdy_b),
      .FB_PKfbData(dat_b), .FB_PKfbPush(push_b), .FB_PKfbSOF(sof_b),
      .FB_PKfbEOF(eof_b), .FB_PKfbOverflow(ovf_b), .ovf_clr(clr_b),
      .ovf_sticky(stk_b), .ovf_cnt(ocnt_b), .pkt_cnt(pcnt_b), .busy(busy_b));

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q_a[$];
   exp_t q_b[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end
   endtask

   function automatic void exp_a(input logic [31:0] d, input logic [3:0] p, input logic s, input logic e);
      exp_t x;
      x.d = d; x.p = p; x.sof = s; x.eof = e;
      q_a.push_back(x);
   endfunction

   function automatic void exp_b(input logic [31:0] d, input logic [3:0] p, input logic s, input logic e);
      exp_t x;
      x.d = d; x.p = p; x.sof = s; x.eof = e;
      q_b.push_back(x);
   endfunction

   // monitor A: every push is compared against the next expected word
   always @(negedge clk) begin
      exp_t a;
      exp_t e;
      if (push_a !== 4'd0) begin
         a.d = dat_a; a.p = push_a; a.sof = sof_a; a.eof = eof_a;
         if (q_a.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_a_unexpected: got %h expected no push", a);
         end else begin
            e = q_a.pop_front();
            check("push_a", 64'(a), 64'(e));
         end
      end
   end

   // monitor B
   always @(negedge clk) begin
      exp_t a;
      exp_t e;
      if (push_b !== 4'd0) begin
         a.d = dat_b; a.p = push_b; a.sof = sof_b; a.eof = eof_b;
         if (q_b.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL push_b_unexpected: got %h expected no push", a);
         end else begin
            e = q_b.pop_front();
            check("push_b", 64'(a), 64'(e));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // offer one word to A; returns #1 after the edge that accepted it
   task automatic send_a(input logic [31:0] d);
      bit acc;
      int guard;
      guard = 0;
      din_a = d;
      vld_a = 1'b1;
      do begin
         acc = rdy_a;
         tick(1);
         guard++;
      end while (!acc && guard < 100);
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_a_timeout: word %h not accepted, required accept within 100 cycles", d);
      end
   endtask

   task automatic send_b(input logic [31:0] d);
      bit acc;
      int guard;
      guard = 0;
      din_b = d;
      vld_b = 1'b1;
      do begin
         acc = rdy_b;
         tick(1);
         guard++;
      end while (!acc && guard < 100);
      if (!acc) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_b_timeout: word %h not accepted, required accept within 100 cycles", d);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // ---------------- reset state
      tick(3);
      check("rst_data", 64'(dat_a), 64'd0);
      check("rst_push", 64'(push_a), 64'd0);
      check("rst_sofeof", 64'({sof_a, eof_a}), 64'd0);
      check("rst_ovf", 64'({stk_a, ocnt_a}), 64'd0);
      check("rst_pkt", 64'(pcnt_a), 64'd0);
      check("rst_busy", 64'(busy_a), 64'd0);
      check("rst_pkt_b", 64'(pcnt_b), 64'd0);
      rst = 1'b0;
      tick(1);
      check("rst_ready", 64'(rdy_a), 64'd1);

      // ---------------- basic 4-word packet on FIFO 2
      en_a = 1'b1; sel_a = 2'd2;
      exp_a(32'h10, 4'b0100, 1'b1, 1'b0);
      exp_a(32'h11, 4'b0100, 1'b0, 1'b0);
      exp_a(32'h12, 4'b0100, 1'b0, 1'b0);
      exp_a(32'h13, 4'b0100, 1'b0, 1'b1);
      send_a(32'h10);
      send_a(32'h11);
      // first word pushed one cycle after its pop
      check("lat_push", 64'(push_a), 64'(4'b0100));
      check("lat_data", 64'(dat_a), 64'h10);
      check("lat_sof", 64'(sof_a), 64'd1);
      check("lat_busy", 64'(busy_a), 64'd1);
      send_a(32'h12);
      send_a(32'h13);
      vld_a = 1'b0;
      tick(3);
      check("p1_pkt", 64'(pcnt_a), 64'd1);
      check("p1_busy", 64'(busy_a), 64'd0);

      // ---------------- fill FIFO with en=0, then drain
      en_a = 1'b0;
      for (int i = 0; i < 8; i++) begin
         exp_a(32'h20 + 32'(i), 4'b0100, (i % 4) == 0, (i % 4) == 3);
      end
      for (int i = 0; i < 8; i++) begin
         send_a(32'h20 + 32'(i));
      end
      check("full_ready", 64'(rdy_a), 64'd0);
      din_a = 32'h28;
      vld_a = 1'b1;
      tick(2);
      check("full_ready_hold", 64'(rdy_a), 64'd0);
      check("full_idle", 64'(busy_a), 64'd0);
      vld_a = 1'b0;
      en_a = 1'b1;
      tick(1);
      check("full_ready_back", 64'(rdy_a), 64'd1);
      tick(14);
      check("full_pkt", 64'(pcnt_a), 64'd3);
      check("full_drained", 64'(q_a.size()), 64'd0);

      // ---------------- source gap mid-packet
      exp_a(32'h30, 4'b0100, 1'b1, 1'b0);
      exp_a(32'h31, 4'b0100, 1'b0, 1'b0);
      exp_a(32'h32, 4'b0100, 1'b0, 1'b0);
      exp_a(32'h33, 4'b0100, 1'b0, 1'b1);
      send_a(32'h30);
      send_a(32'h31);
      vld_a = 1'b0;
      tick(2);
      check("gap_push1", 64'({push_a, sof_a}), 64'd0);
      check("gap_busy", 64'(busy_a), 64'd1);
      tick(1);
      check("gap_push2", 64'({push_a, sof_a}), 64'd0);
      send_a(32'h32);
      send_a(32'h33);
      vld_a = 1'b0;
      tick(4);
      check("gap_pkt", 64'(pcnt_a), 64'd4);

      // ---------------- fifo_sel change during SEND
      for (int i = 0; i < 4; i++) exp_a(32'h50 + 32'(i), 4'b0100, i == 0, i == 3);
      for (int i = 0; i < 4; i++) exp_a(32'h54 + 32'(i), 4'b0010, i == 0, i == 3);
      send_a(32'h50);
      send_a(32'h51);
      check("sel_busy", 64'(busy_a), 64'd1);
      sel_a = 2'd1;
      for (int i = 2; i < 8; i++) send_a(32'h50 + 32'(i));
      vld_a = 1'b0;
      tick(6);
      check("sel_pkt", 64'(pcnt_a), 64'd6);
      check("sel_drained", 64'(q_a.size()), 64'd0);

      // ---------------- overflow status
      ovf_a = 1'b1;
      tick(10);
      check("ovf_cnt10", 64'({stk_a, ocnt_a}), 64'({1'b1, 8'd10}));
      tick(290);
      check("ovf_sat", 64'({stk_a, ocnt_a}), 64'({1'b1, 8'hFF}));
      clr_a = 1'b1;
      tick(1);
      check("ovf_clr_both", 64'({stk_a, ocnt_a}), 64'({1'b1, 8'd1}));
      ovf_a = 1'b0;
      tick(1);
      check("ovf_clr", 64'({stk_a, ocnt_a}), 64'd0);
      clr_a = 1'b0;
      tick(1);

      // ---------------- reset flushes buffered words
      en_a = 1'b0;
      send_a(32'h64);
      send_a(32'h65);
      vld_a = 1'b0;
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      en_a = 1'b1;
      tick(5);
      check("flush_nopush", 64'(push_a), 64'd0);
      check("flush_ready", 64'(rdy_a), 64'd1);
      check("flush_pkt", 64'(pcnt_a), 64'd0);

      // ---------------- reset after word 2 of 4
      sel_a = 2'd2;
      exp_a(32'h60, 4'b0100, 1'b1, 1'b0);
      exp_a(32'h61, 4'b0100, 1'b0, 1'b0);
      send_a(32'h60);
      send_a(32'h61);
      vld_a = 1'b0;
      tick(1);
      rst = 1'b1;
      tick(1);
      check("mid_data", 64'(dat_a), 64'd0);
      check("mid_push", 64'({push_a, sof_a, eof_a}), 64'd0);
      check("mid_busy", 64'(busy_a), 64'd0);
      check("mid_ready", 64'(rdy_a), 64'd1);
      rst = 1'b0;
      check("mid_drained", 64'(q_a.size()), 64'd0);
      for (int i = 0; i < 4; i++) exp_a(32'h70 + 32'(i), 4'b0100, i == 0, i == 3);
      send_a(32'h70);
      vld_a = 1'b0;
      tick(1);
      check("new_sof", 64'({push_a, sof_a}), 64'({4'b0100, 1'b1}));
      check("new_pkt0", 64'(pcnt_a), 64'd0);
      send_a(32'h71);
      send_a(32'h72);
      send_a(32'h73);
      vld_a = 1'b0;
      tick(4);
      check("new_pkt1", 64'(pcnt_a), 64'd1);

      // ---------------- PKT_WORDS=1: SOF and EOF on every push
      en_b = 1'b1;
      sel_b = 2'd3;
      exp_b(32'h80, 4'b1000, 1'b1, 1'b1);
      exp_b(32'h81, 4'b1000, 1'b1, 1'b1);
      exp_b(32'h82, 4'b1000, 1'b1, 1'b1);
      send_b(32'h80);
      send_b(32'h81);
      send_b(32'h82);
      vld_b = 1'b0;
      tick(4);
      check("b_pkt", 64'(pcnt_b), 64'd3);
      check("b_busy", 64'(busy_b), 64'd0);

      check("a_queue_empty", 64'(q_a.size()), 64'd0);
      check("b_queue_empty", 64'(q_b.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
